rd_fifo_unpack: RTL and testbench



---
 rtl/rd_fifo_unpack_if.sv | 39 +++
 rtl/rd_fifo_unpack.sv | 107 ++++++++++
 tb/tb_rd_fifo_unpack.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rd_fifo_unpack_if.sv
// rd_fifo_unpack_if: bundle of the FIFO write port, status flags and the
// unpacked output stream of rd_fifo_unpack.
//   master : the surrounding logic (reader write strobe, consumer ready, flush)
//   slave  : the rd_fifo_unpack instance
// Signals:
//   fifo_wr_en / fifo_wr_data  write strobe and DATA_WIDTH word from the reader
//   fifo_full / burst_space    memory full / at least BURST_LEN words free
//   level                      words held in memory (output stage excluded)
//   out_valid / out_data / out_ready  OUT_WIDTH sub-word stream
//   flush                      synchronous clear
//   overflow                   sticky write-while-full indication
interface rd_fifo_unpack_if #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 16,
  parameter int DEPTH      = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;
  logic                  fifo_full;
  logic                  burst_space;
  logic [LW-1:0]         level;
  logic                  out_valid;
  logic [OUT_WIDTH-1:0]  out_data;
  logic                  out_ready;
  logic                  flush;
  logic                  overflow;

  modport master (
    output fifo_wr_en, fifo_wr_data, out_ready, flush,
    input  fifo_full, burst_space, level, out_valid, out_data, overflow
  );

  modport slave (
    input  fifo_wr_en, fifo_wr_data, out_ready, flush,
    output fifo_full, burst_space, level, out_valid, out_data, overflow
  );
endinterface

// File: rtl/rd_fifo_unpack.sv
// rd_fifo_unpack: buffers full-width AXI read beats in a synchronous FIFO and
// unpacks each word into RATIO = DATA_WIDTH/OUT_WIDTH sub-words on a
// valid/ready stream.
// Ports:
//   clk  single rising-edge clock
//   rst  synchronous active-high reset
//   bus  rd_fifo_unpack_if.slave (write port, flags, output stream, flush)
// Build option:
//   RD_FIFO_UNPACK_MSB_FIRST_EN  when defined, sub-word 0 is the most
//   significant OUT_WIDTH bits; otherwise sub-word 0 is the least significant.
module rd_fifo_unpack #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 16,
  parameter int DEPTH      = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic            clk,
  input  logic            rst,
  rd_fifo_unpack_if.slave bus
);
  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int SW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] hold;
  logic [SW-1:0]         sub_idx;
  logic                  out_valid_q;
  logic                  overflow_q;
  logic [OUT_WIDTH-1:0]  out_data_mux;

  logic [PW-1:0] level;
  logic          full, empty, xfer, last, load, wr_ok;

  // Flags depend only on the registered pointers, never on this cycle's
  // fifo_wr_en/out_ready.
  assign level = wr_ptr - rd_ptr;
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

  assign xfer  = out_valid_q && bus.out_ready;
  assign last  = (sub_idx == SW'(RATIO - 1));
  // Refill on the same edge the final sub-word leaves: no bubble between words.
  assign load  = !empty && (!out_valid_q || (xfer && last));
  assign wr_ok = bus.fifo_wr_en && !full && !rst && !bus.flush;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[AW-1:0]] <= bus.fifo_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      hold        <= '0;
      sub_idx     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (bus.fifo_wr_en) begin
        if (!full) begin
          wr_ptr <= wr_ptr + PW'(1);
        end else begin
          overflow_q <= 1'b1;
        end
      end

      if (load) begin
        hold        <= mem[rd_ptr[AW-1:0]];
        rd_ptr      <= rd_ptr + PW'(1);
        sub_idx     <= '0;
        out_valid_q <= 1'b1;
      end else if (xfer) begin
        if (last) begin
          sub_idx     <= '0;
          out_valid_q <= 1'b0;
        end else begin
          sub_idx <= sub_idx + SW'(1);
        end
      end
    end
  end

  always_comb begin
    out_data_mux = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (sub_idx == SW'(i)) begin
`ifdef RD_FIFO_UNPACK_MSB_FIRST_EN
        out_data_mux = hold[(RATIO - 1 - i) * OUT_WIDTH +: OUT_WIDTH];
`else
        out_data_mux = hold[i * OUT_WIDTH +: OUT_WIDTH];
`endif
      end
    end
  end

  assign bus.fifo_full   = full;
  assign bus.burst_space = (PW'(DEPTH) - level) >= PW'(BURST_LEN);
  assign bus.level       = level;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_mux;
  assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_rd_fifo_unpack.sv
// tb_rd_fifo_unpack: directed sequence with randomized data, checked every
// cycle against a queue-based reference model of the FIFO and output stage.
module tb_rd_fifo_unpack;
  localparam int DW    = 64;
  localparam int OW    = 16;
  localparam int DEPTH = 32;
  localparam int BL    = 16;
  localparam int RATIO = DW / OW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rd_fifo_unpack_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DEPTH)) bus ();

  rd_fifo_unpack #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: words waiting in memory, plus the word in the output stage.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] hold_m = '0;
  int            idx_m  = 0;
  bit            vld_m  = 0;
  bit            ovf_m  = 0;

  logic [OW-1:0] got_q[$];
  logic [OW-1:0] exp_q[$];

  function automatic logic [OW-1:0] sub(logic [DW-1:0] w, int i);
`ifdef RD_FIFO_UNPACK_MSB_FIRST_EN
    return OW'(w >> (OW * (RATIO - 1 - i)));
`else
    return OW'(w >> (OW * i));
`endif
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_tick();
    bit full_pre, xfer, lst, ld;
    if (rst || bus.flush) begin
      mq.delete();
      hold_m = '0; idx_m = 0; vld_m = 0; ovf_m = 0;
    end else begin
      full_pre = (mq.size() == DEPTH);
      xfer     = vld_m && bus.out_ready;
      lst      = xfer && (idx_m == RATIO - 1);
      ld       = (mq.size() > 0) && (!vld_m || lst);
      if (ld) begin
        hold_m = mq.pop_front(); idx_m = 0; vld_m = 1;
      end else if (xfer) begin
        if (lst) begin vld_m = 0; idx_m = 0; end
        else idx_m++;
      end
      if (bus.fifo_wr_en) begin
        if (!full_pre) mq.push_back(bus.fifo_wr_data);
        else ovf_m = 1;
      end
    end
  endtask

  // One clock: model update at the edge, DUT sampled 1 time unit later.
  task automatic step();
    logic          pre_v, stall;
    logic [OW-1:0] pre_d;
    pre_v = bus.out_valid;
    pre_d = bus.out_data;
    stall = pre_v && !bus.out_ready && !rst && !bus.flush;
    if (pre_v === 1'b1 && bus.out_ready && !rst && !bus.flush) got_q.push_back(pre_d);
    @(posedge clk);
    model_tick();
    #1;
    check("level",       64'(bus.level),       64'(mq.size()));
    check("fifo_full",   64'(bus.fifo_full),   64'(mq.size() == DEPTH));
    check("burst_space", 64'(bus.burst_space), 64'((DEPTH - mq.size()) >= BL));
    check("out_valid",   64'(bus.out_valid),   64'(vld_m));
    check("out_data",    64'(bus.out_data),    64'(sub(hold_m, idx_m)));
    check("overflow",    64'(bus.overflow),    64'(ovf_m));
    if (stall) check("stall_stable", 64'(bus.out_data), 64'(pre_d));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    logic [OW-1:0] t2_exp [RATIO];
    logic [OW-1:0] s;
    bit            bs_seen;
    int            n_wr, guard;

    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    bus.out_ready    = 1'b0;
    bus.flush        = 1'b0;

    // 1: reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_valid", 64'(bus.out_valid), 64'(0));
    check("rst_full",  64'(bus.fifo_full), 64'(0));
    check("rst_bs",    64'(bus.burst_space), 64'(1));
    check("rst_level", 64'(bus.level), 64'(0));
    check("rst_ovf",   64'(bus.overflow), 64'(0));

    // 2: single word latency and sub-word order
`ifdef RD_FIFO_UNPACK_MSB_FIRST_EN
    t2_exp = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
`else
    t2_exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
`endif
    bus.out_ready    = 1'b1;
    bus.fifo_wr_en   = 1'b1;
    bus.fifo_wr_data = 64'h4444_3333_2222_1111;
    step();
    bus.fifo_wr_en = 1'b0;
    check("t2_cycle1_valid", 64'(bus.out_valid), 64'(0));
    for (int i = 0; i < RATIO; i++) begin
      step();
      check("t2_valid", 64'(bus.out_valid), 64'(1));
      check("t2_data",  64'(bus.out_data),  64'(t2_exp[i]));
    end
    step();
    check("t2_cycle6_valid", 64'(bus.out_valid), 64'(0));

    // 3: fill to full while stalled, word 33 dropped
    bus.out_ready = 1'b0;
    bs_seen = 0;
    for (int i = 0; i < 34; i++) begin
      bus.fifo_wr_en   = 1'b1;
      bus.fifo_wr_data = {$urandom, $urandom};
      if (i == 0) w = bus.fifo_wr_data;
      step();
      if (!bs_seen && bus.burst_space === 1'b0) begin
        bs_seen = 1;
        check("t3_bs_drop_level", 64'(bus.level), 64'(17));
      end
    end
    bus.fifo_wr_en = 1'b0;
    check("t3_bs_dropped", 64'(bs_seen), 64'(1));
    check("t3_level", 64'(bus.level), 64'(32));
    check("t3_full",  64'(bus.fifo_full), 64'(1));
    check("t3_ovf",   64'(bus.overflow), 64'(1));
    check("t3_word0_held", 64'(bus.out_data), 64'(sub(w, 0)));

    // 5: write on the final sub-word pop of a full FIFO is rejected
    bus.out_ready = 1'b1;
    for (int i = 0; i < RATIO - 1; i++) step();
    bus.fifo_wr_en   = 1'b1;
    bus.fifo_wr_data = {$urandom, $urandom};
    step();
    bus.fifo_wr_en = 1'b0;
    check("t5_level", 64'(bus.level), 64'(31));
    check("t5_full",  64'(bus.fifo_full), 64'(0));

    // 6: flush with level 10 and sub-index 2
    guard = 0;
    while ((mq.size() != 10 || idx_m != 2) && guard < 400) begin
      step();
      guard++;
    end
    check("t6_reach_level", 64'(bus.level), 64'(10));
    check("t6_ovf_before",  64'(bus.overflow), 64'(1));
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("t6_level", 64'(bus.level), 64'(0));
    check("t6_valid", 64'(bus.out_valid), 64'(0));
    check("t6_ovf",   64'(bus.overflow), 64'(0));
    bus.out_ready    = 1'b0;
    bus.fifo_wr_en   = 1'b1;
    bus.fifo_wr_data = {$urandom, $urandom};
    w = bus.fifo_wr_data;
    step();
    bus.fifo_wr_en = 1'b0;
    step();
    check("t6_post_valid", 64'(bus.out_valid), 64'(1));
    check("t6_post_sub0",  64'(bus.out_data), 64'(sub(w, 0)));

    // 4: 64 incrementing words, ready toggling, pointers wrap twice
    rst = 1'b1;
    step();
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
    s = OW'($urandom);
    n_wr = 0;
    guard = 0;
    bus.out_ready = 1'b0;
    while (got_q.size() < 256 && guard < 3000) begin
      bus.out_ready = ~bus.out_ready;
      if (n_wr < 64 && mq.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        w = {OW'(s + OW'(4 * n_wr + 3)), OW'(s + OW'(4 * n_wr + 2)),
             OW'(s + OW'(4 * n_wr + 1)), OW'(s + OW'(4 * n_wr))};
        bus.fifo_wr_en   = 1'b1;
        bus.fifo_wr_data = w;
        for (int k = 0; k < RATIO; k++) exp_q.push_back(sub(w, k));
        n_wr++;
      end else begin
        bus.fifo_wr_en = 1'b0;
      end
      step();
      guard++;
    end
    bus.fifo_wr_en = 1'b0;
    check("t4_count", 64'(got_q.size()), 64'(256));
    for (int i = 0; i < 256 && i < got_q.size(); i++) begin
      check("t4_order", 64'(got_q[i]), 64'(exp_q[i]));
    end
    step();
    check("t4_drained_valid", 64'(bus.out_valid), 64'(0));
    check("t4_drained_level", 64'(bus.level), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
